// File: rtl/button_input_port.sv
// Input-port responder for the clock CPU: debounced button levels, sticky press
// events and a saturating press counter, read through a small read-to-clear port map.
module button_input_port #(
    parameter int unsigned N_BUTTONS       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_BUTTONS-1:0] buttons,
    input  logic                 read_in,
    input  logic [3:0]           in_port,
    output logic [15:0]          in_data,
    output logic [N_BUTTONS-1:0] pressed
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned     RISE_W   = $clog2(N_BUTTONS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]     ID_WORD  = {8'hB1, 4'h0, 4'(N_BUTTONS)};

    localparam logic [3:0] PORT_LEVEL = 4'd0;
    localparam logic [3:0] PORT_EVENT = 4'd1;
    localparam logic [3:0] PORT_COUNT = 4'd2;
    localparam logic [3:0] PORT_ID    = 4'd3;

    logic [N_BUTTONS-1:0] pin_norm;
    logic [N_BUTTONS-1:0] sync_q;
    logic [N_BUTTONS-1:0] samp_q;
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];
    logic [N_BUTTONS-1:0] pressed_d;
    logic [N_BUTTONS-1:0] rise;
    logic [N_BUTTONS-1:0] event_q;
    logic [N_BUTTONS-1:0] event_d;
    logic [7:0]           press_count_q;
    logic [7:0]           press_count_d;
    logic [RISE_W-1:0]    rise_num;
    logic [8:0]           count_sum;
    logic                 clr_event;
    logic                 clr_count;

    // Pressed is normalised to 1 before synchronising, so reset (0) means released.
    assign pin_norm  = ACTIVE_LOW ? ~buttons : buttons;
    assign clr_event = read_in && (in_port == PORT_EVENT);
    assign clr_count = read_in && (in_port == PORT_COUNT);

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        pressed_d = pressed;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (samp_q[i] != pressed[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    pressed_d[i] = samp_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edges set events and bump the counter; a same-cycle clear keeps the new rises.
    always_comb begin
        rise     = pressed_d & ~pressed;
        rise_num = '0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            rise_num = rise_num + RISE_W'(rise[i]);
        end
        count_sum = 9'(press_count_q) + 9'(rise_num);
        event_d   = clr_event ? rise : (event_q | rise);
        if (clr_count) begin
            press_count_d = 8'(rise_num);
        end else if (count_sum > 9'd255) begin
            press_count_d = 8'hFF;
        end else begin
            press_count_d = count_sum[7:0];
        end
    end

    // Read data reflects state before any clear caused by this cycle's read.
    always_comb begin
        in_data = 16'h0000;
        case (in_port)
            PORT_LEVEL: in_data = 16'(pressed);
            PORT_EVENT: in_data = 16'(event_q);
            PORT_COUNT: in_data = {8'h00, press_count_q};
            PORT_ID:    in_data = ID_WORD;
            default:    in_data = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q        <= '0;
            samp_q        <= '0;
            pressed       <= '0;
            event_q       <= '0;
            press_count_q <= '0;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q        <= pin_norm;
            samp_q        <= sync_q;
            pressed       <= pressed_d;
            event_q       <= event_d;
            press_count_q <= press_count_d;
            for (int unsigned i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_button_input_port.sv
// Randomised and directed checks of button_input_port against a window-based
// behavioural model of debounce, events and the saturating press counter.
module tb_button_input_port;

    localparam int unsigned N = 3;
    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  buttons = 3'b111;
    logic        read_in = 1'b0;
    logic [3:0]  in_port = 4'd0;
    logic [15:0] in_data;
    logic [2:0]  pressed;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [2:0]  m_s1, m_samp, m_pressed, m_event;
    int          m_count;
    logic [2:0]  hist[$];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    button_input_port #(
        .N_BUTTONS(N),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .buttons(buttons),
        .read_in(read_in),
        .in_port(in_port),
        .in_data(in_data),
        .pressed(pressed)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] p);
        case (p)
            4'd0:    return {13'd0, m_pressed};
            4'd1:    return {13'd0, m_event};
            4'd2:    return 16'(m_count);
            4'd3:    return 16'hB103;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_samp = '0; m_pressed = '0; m_event = '0; m_count = 0;
        hist.delete();
    endtask

    // A level is accepted when the last D synchronised samples all disagree with it.
    task automatic model_edge(input logic [2:0] btn, input logic rd, input logic [3:0] p);
        logic [2:0] nxt, rises;
        logic       all_diff;
        int         pop;
        hist.push_back(m_samp);
        if (hist.size() > D) void'(hist.pop_front());
        nxt = m_pressed;
        for (int i = 0; i < int'(N); i++) begin
            if (hist.size() == D) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][i] == m_pressed[i]) all_diff = 1'b0;
                if (all_diff) nxt[i] = m_samp[i];
            end
        end
        rises = nxt & ~m_pressed;
        pop = $countones(rises);
        if (rd && p == 4'd1) m_event = rises;
        else                 m_event = m_event | rises;
        if (rd && p == 4'd2) m_count = pop;
        else                 m_count = (m_count + pop > 255) ? 255 : m_count + pop;
        m_pressed = nxt;
        m_samp    = m_s1;
        m_s1      = ~btn;
    endtask

    task automatic tick(input logic [2:0] btn, input logic rd, input logic [3:0] p);
        buttons = btn; read_in = rd; in_port = p;
        #1;
        last_rd = in_data;
        check("in_data", in_data, m_read(p));
        model_edge(btn, rd, p);
        @(posedge clk);
        #1;
        check("pressed", 16'(pressed), 16'(m_pressed));
    endtask

    task automatic release_all();
        repeat (8) tick(3'b111, 1'b0, 4'd0);
    endtask

    logic [15:0] id_exp [4];
    logic [2:0]  rbtn;
    logic [3:0]  rport;
    int          hold;

    initial begin
        id_exp[0] = 16'h0000; id_exp[1] = 16'h0000; id_exp[2] = 16'h0000; id_exp[3] = 16'hB103;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset state and port map
        for (int p = 0; p < 4; p++) begin
            tick(3'b111, 1'b1, 4'(p));
            check("reset_port", last_rd, id_exp[p]);
        end
        tick(3'b111, 1'b1, 4'd9);
        check("unmapped_port9", last_rd, 16'h0000);

        // Clean press of button 0: six-edge latency
        for (int k = 1; k <= 6; k++) begin
            tick(3'b110, 1'b0, 4'd0);
            if (k == 5) check("latency_edge5", 16'(pressed), 16'h0000);
            if (k == 6) check("latency_edge6", 16'(pressed), 16'h0001);
        end
        tick(3'b110, 1'b1, 4'd1); check("event_first", last_rd, 16'h0001);
        tick(3'b110, 1'b1, 4'd1); check("event_cleared", last_rd, 16'h0000);
        tick(3'b110, 1'b1, 4'd2); check("count_one", last_rd, 16'h0001);
        release_all();

        // Glitch rejection and bounce on button 1
        repeat (3) tick(3'b101, 1'b0, 4'd0);
        release_all();
        check("glitch_pressed", 16'(pressed), 16'h0000);
        tick(3'b111, 1'b1, 4'd1); check("glitch_event", last_rd, 16'h0000);
        repeat (2) tick(3'b101, 1'b0, 4'd0);
        tick(3'b111, 1'b0, 4'd0);
        repeat (8) tick(3'b101, 1'b0, 4'd0);
        tick(3'b101, 1'b1, 4'd1); check("bounce_event", last_rd, 16'h0002);
        tick(3'b101, 1'b1, 4'd1); check("bounce_event_clr", last_rd, 16'h0000);
        release_all();
        tick(3'b111, 1'b1, 4'd2); check("bounce_count", last_rd, 16'h0001);

        // Event on the same edge as a port-1 clear
        repeat (7) tick(3'b110, 1'b0, 4'd0);
        repeat (5) tick(3'b010, 1'b0, 4'd0);
        tick(3'b010, 1'b1, 4'd1); check("clr_race_first", last_rd, 16'h0001);
        tick(3'b010, 1'b1, 4'd1); check("clr_race_second", last_rd, 16'h0004);
        release_all();
        tick(3'b111, 1'b1, 4'd2); check("release_not_counted", last_rd, 16'h0002);

        // Counter saturation
        repeat (260) begin
            repeat (5) tick(3'b110, 1'b0, 4'd0);
            repeat (5) tick(3'b111, 1'b0, 4'd0);
        end
        tick(3'b111, 1'b1, 4'd2); check("count_saturated", last_rd, 16'h00FF);
        tick(3'b111, 1'b1, 4'd2); check("count_after_clr", last_rd, 16'h0000);
        tick(3'b111, 1'b1, 4'd1);

        // Reset in mid-debounce
        repeat (5) tick(3'b110, 1'b0, 4'd0);
        rstn = 1'b0; in_port = 4'd3;
        model_reset();
        #1;
        check("rst_pressed", 16'(pressed), 16'h0000);
        check("rst_id", in_data, 16'hB103);
        #1 rstn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(3'b110, 1'b0, 4'd0);
            if (k == 5) check("rst_requal_edge5", 16'(pressed), 16'h0000);
            if (k == 6) check("rst_requal_edge6", 16'(pressed), 16'h0001);
        end
        tick(3'b110, 1'b1, 4'd1); check("rst_fresh_event", last_rd, 16'h0001);
        tick(3'b110, 1'b1, 4'd2); check("rst_fresh_count", last_rd, 16'h0001);
        release_all();

        // Random button activity and reads against the model
        repeat (400) begin
            rbtn = 3'($urandom);
            hold = $urandom_range(1, 7);
            repeat (hold) begin
                rport = 4'($urandom_range(0, 5));
                if (rport == 4'd5) rport = 4'($urandom_range(4, 15));
                tick(rbtn, ($urandom_range(0, 2) == 0), rport);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/button_input_port.md
# button_input_port

Input-side port responder for the clock CPU's driver: it answers the CPU's input-port reads with debounced button state and latched press events. It is the counterpart of the output-port writer that feeds the time/date display registers. Raw board buttons enter here, and the CPU sees only clean, synchronized values. The block sits between the board button pins and the driver's `in_data` input in the FPGA top level.

## Interface

Parameters:
- `N_BUTTONS`, default 3: number of button inputs, 1..8.
- `DEBOUNCE_CYCLES`, default 50000: cycles a new level must stay stable before it is accepted, ≥2.
- `ACTIVE_LOW`, default 1: 1 means a raw pin at 0 is "pressed".

Ports (clock and reset first):
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `buttons` in N_BUTTONS: raw, asynchronous button pins.
- `read_in` in 1: CPU read strobe, one cycle per read.
- `in_port` in 4: port number being read.
- `in_data` out 16: read data, combinational from `in_port` and internal state.
- `pressed` out N_BUTTONS: debounced level, 1 means pressed.

## Operation

Per-button input path:
- The raw pin is optionally inverted when `ACTIVE_LOW`=1, then passed through a 2-flop synchronizer. The synchronizer output is `samp[i]`.
- Debounce counter `cnt[i]` has width clog2(DEBOUNCE_CYCLES).
  - If `samp[i]` equals `pressed[i]`: `cnt[i]` is cleared to 0.
  - Otherwise `cnt[i]` increments.
  - When `cnt[i]` equals DEBOUNCE_CYCLES-1 and `samp[i]` still differs: `pressed[i]` takes `samp[i]` and `cnt[i]` is cleared.
- A glitch shorter than DEBOUNCE_CYCLES never changes `pressed`.
- A 0→1 transition of `pressed[i]` sets sticky flag `event[i]`. A 1→0 transition sets no flag.
- `press_count` is 8 bits. It increments by the number of buttons whose `pressed` rises in that cycle and saturates at 255.

Port map (read data):
- Port 0: {zero-extend, `pressed`}.
- Port 1: {zero-extend, `event`}. This port is read-to-clear.
- Port 2: {8'h00, `press_count`}. This port is read-to-clear.
- Port 3: constant {8'hB1, 4'h0, N_BUTTONS[3:0]}, an identification word.
- Ports 4..15: 16'h0000.

Read-to-clear rules:
- The clear happens on the rising edge that ends a cycle in which `read_in`=1 and `in_port` selects port 1 or port 2.
- Reads of ports 0 and 3, and reads of unmapped ports, have no side effects.
- If an event for button i occurs in the same cycle as a port-1 clear, `event[i]` ends at 1. The new event is not lost; only bits that were returned are cleared.
- If a press occurs in the same cycle as a port-2 clear, `press_count` ends at the number of new rises in that cycle, not 0.

## Timing

- Reset values, applied asynchronously while `rstn`=0:
  - `pressed` = 0, `event` = 0, `press_count` = 0, all `cnt` = 0.
  - Synchronizer flops = 0, the released level after inversion.
  - `in_data` then shows the reset state: port 0 reads 0, port 3 reads its constant.
- Reset in mid-debounce discards the partial count. A button held through reset release must be qualified again and produces a fresh press event.
- Latency from a stable pin change to `pressed` updating is 2 + DEBOUNCE_CYCLES rising edges.
  - 2 edges for the synchronizer.
  - DEBOUNCE_CYCLES edges of mismatch, counting the edge on which `pressed` updates.
- `event` and `press_count` update on the same edge as `pressed`. They are readable in the following cycle.
- `in_data` is valid in the same cycle as `in_port` (combinational, no wait states). It reflects the state from before any clear caused by that cycle's read.
- Back-to-back port-1 reads on consecutive cycles: the second read returns only events set after the first read.
- `read_in`=0 never modifies state, regardless of `in_port`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `N_BUTTONS`=3, `ACTIVE_LOW`=1.

1. **Reset.** Apply reset, then read ports 0..3 → 0x0000, 0x0000, 0x0000, 0xB103. Read port 9 → 0x0000.
2. **Clean press.** Drive `buttons`=3'b110 steadily (button 0 pressed).
   - `pressed`=3'b001 exactly 6 edges after the pin change.
   - Port 1 read → 0x0001, then immediately → 0x0000.
   - Port 2 read → 0x0001.
3. **Glitch rejection.** Drive a 3-cycle low pulse on button 1.
   - `pressed` stays 0 and port 1 reads 0x0000.
   - A bounce pattern of 2 low / 1 high / 5 low cycles produces exactly one event.
4. **Simultaneous clear and event.** Arrange for button 2's `pressed` to rise on the same edge as a port-1 read that returns 0x0001.
   - The next port-1 read returns 0x0004.
   - Release is not counted: after release, port 2 counts only rises.
5. **Saturation.** Generate 260 presses on button 0 with no port-2 read → port 2 returns 0x00FF. After that read, port 2 returns 0x0000.
6. **Reset mid-debounce.** Hold button 0 pressed and assert `rstn`=0 after 3 mismatch cycles.
   - After release of reset, `pressed`=0 until 6 further edges, then 1.
   - Exactly one event results.
